// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// CON bit positions and the frame state encoding used by both directions.
package uart_pkg;

  localparam logic [31:0] TXD_OFS = 32'd0;
  localparam logic [31:0] RXD_OFS = 32'd4;
  localparam logic [31:0] CON_OFS = 32'd8;

  localparam int CON_TX_IE   = 0;
  localparam int CON_RX_IE   = 1;
  localparam int CON_RX_DONE = 2;
  localparam int CON_TX_DONE = 3;
  localparam int CON_TX_BUSY = 4;
  localparam int CON_OVR     = 5;
  localparam int CON_FERR    = 6;
  localparam int CON_LOOP    = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: two-flop synchronizer, falling-edge start detection and
// mid-bit sampling of an 8N1 frame. Reports one-cycle byte/frame-error pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detect
  logic [2:0]      sync_reg;
  logic            synced;
  logic            fall;

  uart_state_e     state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;

  assign synced  = sync_reg[1];
  assign fall    = sync_reg[2] & ~sync_reg[1];
  assign rx_byte = shift_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[1:0], rx_in};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = synced ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == FULL) begin
          cnt_next   = '0;
          shift_next = {synced, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == FULL) begin
          cnt_next   = '0;
          state_next = IDLE;
          byte_valid = synced;
          frame_err  = ~synced;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_peripheral.sv
// Bus-mapped 8N1 UART: TXD/RXD/CON registers, transmit FSM, flags and irq.
// Optional UART_LOOPBACK_EN adds CON bit 7, routing internal tx into the receiver.
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irqout
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [31:0] TXD_ADDR = BASE_ADDR + TXD_OFS;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + RXD_OFS;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + CON_OFS;

  logic txd_wr, rxd_rd, con_wr;
  assign txd_wr = wr && (addr == TXD_ADDR);
  assign rxd_rd = rd && (addr == RXD_ADDR);
  assign con_wr = wr && (addr == CON_ADDR);

  uart_state_e   tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_reg, tx_next;
  logic          tx_done_set;
  logic          tx_busy;

  logic          tx_ie_reg, tx_ie_next;
  logic          rx_ie_reg, rx_ie_next;
  logic          rx_done_reg, rx_done_next;
  logic          tx_done_reg, tx_done_next;
  logic          ovr_reg, ovr_next;
  logic          ferr_reg, ferr_next;
  logic [7:0]    rx_data_reg, rx_data_next;

  logic          loop_bit;
  logic          rx_src;
  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_err;
  logic [31:0]   con_val;

  assign tx      = tx_reg;
  assign tx_busy = (tx_state_reg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
      tx_ie_reg    <= 1'b0;
      rx_ie_reg    <= 1'b0;
      rx_done_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
      ovr_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      rx_data_reg  <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_next;
      tx_ie_reg    <= tx_ie_next;
      rx_ie_reg    <= rx_ie_next;
      rx_done_reg  <= rx_done_next;
      tx_done_reg  <= tx_done_next;
      ovr_reg      <= ovr_next;
      ferr_reg     <= ferr_next;
      rx_data_reg  <= rx_data_next;
    end
  end

  // Transmit FSM; the line level is registered from the next state to stay glitch-free
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_done_set   = 1'b0;
    if (tx_state_reg == IDLE) begin
      if (txd_wr) begin
        tx_state_next = START;
        tx_cnt_next   = '0;
        tx_bit_next   = '0;
        tx_shift_next = wdata[7:0];
      end
    end else if (tx_cnt_reg != FULL) begin
      tx_cnt_next = tx_cnt_reg + CW'(1);
    end else begin
      tx_cnt_next = '0;
      case (tx_state_reg)
        START: tx_state_next = DATA;
        DATA: begin
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = tx_bit_reg + 3'd1;
          if (tx_bit_reg == 3'd7) tx_state_next = STOP;
        end
        STOP: begin
          tx_state_next = IDLE;
          tx_done_set   = 1'b1;
        end
        default: tx_state_next = IDLE;
      endcase
    end
    case (tx_state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = tx_shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Flag updates: clears first, then sets, so a same-cycle set wins
  always_comb begin
    tx_ie_next   = tx_ie_reg;
    rx_ie_next   = rx_ie_reg;
    rx_done_next = rx_done_reg;
    tx_done_next = tx_done_reg;
    ovr_next     = ovr_reg;
    ferr_next    = ferr_reg;
    rx_data_next = rx_data_reg;
    if (con_wr) begin
      tx_ie_next = wdata[CON_TX_IE];
      rx_ie_next = wdata[CON_RX_IE];
      if (wdata[CON_RX_DONE]) rx_done_next = 1'b0;
      if (wdata[CON_TX_DONE]) tx_done_next = 1'b0;
      if (wdata[CON_OVR])     ovr_next     = 1'b0;
      if (wdata[CON_FERR])    ferr_next    = 1'b0;
    end
    if (rxd_rd) rx_done_next = 1'b0;
    if (byte_valid) begin
      rx_done_next = 1'b1;
      rx_data_next = rx_byte;
      if (rx_done_reg && !rxd_rd) ovr_next = 1'b1;
    end
    if (frame_err)   ferr_next    = 1'b1;
    if (tx_done_set) tx_done_next = 1'b1;
  end

`ifdef UART_LOOPBACK_EN
  logic loop_reg;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      loop_reg <= 1'b0;
    else if (con_wr) loop_reg <= wdata[CON_LOOP];
  end
  assign loop_bit = loop_reg;
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:7];
  assign loop_bit = 1'b0;
`endif

  assign rx_src = loop_bit ? tx_reg : rx;

  uart_rx_core #(
    .DIV(DIV)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_src),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign con_val = {24'b0, loop_bit, ferr_reg, ovr_reg, tx_busy,
                    tx_done_reg, rx_done_reg, rx_ie_reg, tx_ie_reg};

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == RXD_ADDR)      rdata = {24'b0, rx_data_reg};
      else if (addr == CON_ADDR) rdata = con_val;
    end
  end

  assign irqout = (tx_ie_reg & tx_done_reg) | (rx_ie_reg & rx_done_reg);

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral at DIV=16: TX framing and timing, RX
// flags, overrun, false start, framing error, async reset and loopback.
module tb_uart_peripheral;

  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        tx;
  logic        irqout;

  int checks = 0;
  int errors = 0;

  uart_peripheral #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .BASE_ADDR(32'h40000018)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rx    (rx),
    .tx    (tx),
    .irqout(irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  // Sends d on TXD and checks each bit mid-period plus the exact tx_done cycle
  // (needs tx_ie=1, tx_done=0). intrude injects a TXD=0xA3 write at cycle 5.
  task automatic tx_frame(input logic [7:0] d, input bit intrude);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    bus_write(TXD, {24'h0, d});
    for (int c = 0; c <= 160; c++) begin
      if (intrude && c == 4) begin
        wr = 1'b1; addr = TXD; wdata = 32'h000000A3;
      end
      if (intrude && c == 5) begin
        wr = 1'b0; addr = '0; wdata = '0;
      end
      if (c % 16 == 8) check($sformatf("tx 0x%02h bit%0d", d, c / 16), {31'b0, tx}, {31'b0, fr[c / 16]});
      if (c == 159) check("irq before done", {31'b0, irqout}, 32'd0);
      if (c == 160) check("irq at done", {31'b0, irqout}, 32'd1);
      if (c < 160) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    // reset state
    #23;
    check("reset tx", {31'b0, tx}, 32'd1);
    check("reset irq", {31'b0, irqout}, 32'd0);
    reset = 1'b1;
    read_check("reset CON", CON, 32'h00);
    read_check("TXD read is 0", TXD, 32'h00);
    addr = CON; rd = 1'b0; #1;
    check("rdata without rd", rdata, 32'h00);
    addr = '0;

    // 1: frame 0x55 with exact done timing
    bus_write(CON, 32'h01);
    tx_frame(8'h55, 1'b0);
    bus_write(CON, 32'h00);
    read_check("CON after tx", CON, 32'h08);

    // 2: write during busy is ignored; W1C of tx_done
    bus_write(CON, 32'h09);
    tx_frame(8'h55, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    check("tx idle after frame", {31'b0, tx}, 32'd1);
    bus_write(CON, 32'h08);
    read_check("CON tx_done cleared", CON, 32'h00);

    // 3: receive 0x3C with rx irq
    bus_write(CON, 32'h02);
    check("irq before rx", {31'b0, irqout}, 32'd0);
    send_rx(8'h3C, 1'b1);
    check("irq after rx", {31'b0, irqout}, 32'd1);
    read_check("CON rx_done", CON, 32'h06);
    read_check("RXD 0x3C", RXD, 32'h3C);
    check("irq after RXD read", {31'b0, irqout}, 32'd0);
    read_check("CON after RXD read", CON, 32'h02);
    bus_write(CON, 32'h00);

    // 4: overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    read_check("CON overrun", CON, 32'h24);
    read_check("RXD overwritten", RXD, 32'h22);
    bus_write(CON, 32'h20);
    read_check("CON ovr cleared", CON, 32'h00);

    // 5: false start, then good frame, then framing error
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    read_check("CON after glitch", CON, 32'h00);
    send_rx(8'h5A, 1'b1);
    read_check("CON after 0x5A", CON, 32'h04);
    read_check("RXD 0x5A", RXD, 32'h5A);
    send_rx(8'h7E, 1'b0);
    read_check("CON ferr", CON, 32'h40);
    read_check("RXD unchanged", RXD, 32'h5A);
    bus_write(CON, 32'h40);
    read_check("CON ferr cleared", CON, 32'h00);

    // 6: async reset mid-frame
    bus_write(CON, 32'h02);
    send_rx(8'h01, 1'b1);
    check("irq before reset", {31'b0, irqout}, 32'd1);
    bus_write(TXD, 32'h00);
    repeat (20) @(posedge clk);
    #1;
    check("tx low mid frame", {31'b0, tx}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("tx on async reset", {31'b0, tx}, 32'd1);
    check("irq on async reset", {31'b0, irqout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    read_check("CON after reset", CON, 32'h00);
    check("tx idle after reset", {31'b0, tx}, 32'd1);

`ifdef UART_LOOPBACK_EN
    bus_write(CON, 32'h80);
    bus_write(TXD, 32'h9C);
    repeat (200) @(posedge clk);
    #1;
    read_check("CON loopback", CON, 32'h8C);
    read_check("RXD loopback", RXD, 32'h9C);
`else
    bus_write(CON, 32'h80);
    read_check("CON bit7 ignored", CON, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
